clock_period_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous periodic input (typically a clock produced by the divider) in units of the system clock `clk`. Synchronizes the input, detects edges, counts `clk` cycles between consecutive rising edges, and publishes one period/high-time pair per input cycle with a valid strobe. It also flags a lock once the measured period is stable and flags a timeout when the input stops toggling. It sits on the measurement side of the clock-generation path and serves as the self-checking counterpart to the divider in benches and in on-chip monitors.

---
 rtl/clock_period_meter_if.sv | 22 ++
 rtl/clock_period_meter.sv | 126 ++++++++++++
 tb/tb_clock_period_meter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/clock_period_meter_if.sv
// Measurement-side bundle of clock_period_meter: the signal under test plus the
// published period/high-time pair with its strobe and status levels.
interface clock_period_meter_if #(
  parameter int countWidth = 16
);
  logic                  measuredClock;
  logic [countWidth-1:0] period;
  logic [countWidth-1:0] highTime;
  logic                  valid;
  logic                  locked;
  logic                  timeout;

  modport master (
    output measuredClock,
    input  period, highTime, valid, locked, timeout
  );

  modport slave (
    input  measuredClock,
    output period, highTime, valid, locked, timeout
  );
endinterface

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous input in clk cycles,
// with a stability lock indicator and a no-edge timeout.
module clock_period_meter #(
  parameter int countWidth    = 16,
  parameter int syncStages    = 2,
  parameter int lockCount     = 4,
  parameter int lockTolerance = 1
) (
  input logic                 clk,
  input logic                 rst,
  clock_period_meter_if.slave mif
);

  localparam logic [countWidth-1:0] CNT_MAX = '1;
  localparam logic [countWidth:0]   TOL     = (countWidth+1)'(lockTolerance);
  localparam logic [3:0]            LOCK_N  = 4'(lockCount);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t                state;
  logic [syncStages-1:0] sync_p0;
  logic                  sprev_p1;
  logic                  s_p0;
  logic                  rise;
  logic                  fall;
  logic [countWidth-1:0] cnt;
  logic [countWidth-1:0] hicap;
  logic [countWidth-1:0] prevperiod;
  logic                  haveprev;
  logic [3:0]            stablecnt;
  logic [3:0]            stablenxt;
  logic                  intol;

  function automatic logic [countWidth:0] abs_diff(input logic [countWidth-1:0] a,
                                                   input logic [countWidth-1:0] b);
    logic signed [countWidth:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

  function automatic logic [countWidth-1:0] sat_inc_cnt(input logic [countWidth-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [3:0] sat_inc_stable(input logic [3:0] v);
    return (v >= LOCK_N) ? LOCK_N : v + 4'd1;
  endfunction

  // Stage p0: synchronizer chain; p1: history flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0  <= '0;
      sprev_p1 <= 1'b0;
    end else begin
      sync_p0  <= {sync_p0[syncStages-2:0], mif.measuredClock};
      sprev_p1 <= s_p0;
    end
  end

  assign s_p0      = sync_p0[syncStages-1];
  assign rise      = s_p0 & ~sprev_p1;
  assign fall      = ~s_p0 & sprev_p1;
  assign intol     = abs_diff(cnt, prevperiod) <= TOL;
  assign stablenxt = sat_inc_stable(stablecnt);

  // Measurement FSM: counter, capture registers, lock and timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      hicap        <= '0;
      prevperiod   <= '0;
      haveprev     <= 1'b0;
      stablecnt    <= '0;
      mif.period   <= '0;
      mif.highTime <= '0;
      mif.valid    <= 1'b0;
      mif.locked   <= 1'b0;
      mif.timeout  <= 1'b0;
    end else begin
      mif.valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rise) begin
            state <= MEASURE;
            cnt   <= {{(countWidth-1){1'b0}}, 1'b1};
          end
        end
        MEASURE: begin
          // A rise on the saturating cycle still yields a normal measurement
          if (rise) begin
            mif.period   <= cnt;
            mif.highTime <= hicap;
            mif.valid    <= 1'b1;
            mif.timeout  <= 1'b0;
            cnt          <= {{(countWidth-1){1'b0}}, 1'b1};
            prevperiod   <= cnt;
            haveprev     <= 1'b1;
            if (!haveprev) begin
              stablecnt <= '0;
            end else if (intol) begin
              stablecnt <= stablenxt;
              if (stablenxt == LOCK_N) mif.locked <= 1'b1;
            end else begin
              stablecnt  <= '0;
              mif.locked <= 1'b0;
            end
          end else if (cnt == CNT_MAX) begin
            mif.timeout <= 1'b1;
            mif.locked  <= 1'b0;
            stablecnt   <= '0;
            haveprev    <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
          end else begin
            cnt <= sat_inc_cnt(cnt);
            if (fall) hicap <= cnt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter driven by a clk-synchronous input.
module tb_clock_period_meter;

  localparam int CW = 6;
  localparam int LOCKN = 4;
  localparam int TOLR = 1;

  logic clk;
  logic rst;

  clock_period_meter_if #(.countWidth(CW)) mif ();

  clock_period_meter #(
    .countWidth(CW), .syncStages(2), .lockCount(LOCKN), .lockTolerance(TOLR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   per;
    int   hi;
    logic lk;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // reference model state
  logic armed, have_prev, lk;
  int   prev_per, stable, prev_h, prev_l, last_per, last_hi;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    armed = 0; have_prev = 0; lk = 0; stable = 0; prev_per = 0;
  endtask

  task automatic cycle(input int h, input int l);
    exp_t e;
    int per, d;
    if (armed) begin
      per = prev_h + prev_l;
      if (!have_prev) begin
        have_prev = 1;
        stable = 0;
      end else begin
        d = (per > prev_per) ? per - prev_per : prev_per - per;
        if (d <= TOLR) stable = (stable < LOCKN) ? stable + 1 : LOCKN;
        else begin
          stable = 0;
          lk = 0;
        end
        if (stable == LOCKN) lk = 1;
      end
      prev_per = per;
      e.per = per; e.hi = prev_h; e.lk = lk;
      q.push_back(e);
      last_per = per; last_hi = prev_h;
    end
    armed = 1; prev_h = h; prev_l = l;
    mif.measuredClock = 1'b1;
    repeat (h) @(negedge clk);
    mif.measuredClock = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && mif.valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("period", int'(mif.period), e.per);
        chk("highTime", int'(mif.highTime), e.hi);
        chk("locked", int'(mif.locked), int'(e.lk));
        chk("timeout_on_valid", int'(mif.timeout), 0);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_period"},   int'(mif.period), 0);
    chk({tag, "_highTime"}, int'(mif.highTime), 0);
    chk({tag, "_valid"},    int'(mif.valid), 0);
    chk({tag, "_locked"},   int'(mif.locked), 0);
    chk({tag, "_timeout"},  int'(mif.timeout), 0);
  endtask

  initial begin
    rst = 1'b1;
    mif.measuredClock = 1'b0;
    model_reset();
    last_per = 0; last_hi = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // idle with no input edges
    repeat (20) @(negedge clk);
    check_outputs_zero("idle");

    // divide-by-10, 50% duty, then 3/7 duty
    for (int i = 0; i < 7; i++) cycle(5, 5);
    chk("locked_after_div10", int'(mif.locked), 1);
    for (int i = 0; i < 4; i++) cycle(3, 7);
    chk("locked_after_duty", int'(mif.locked), 1);

    // period jump to 14 and relock
    for (int i = 0; i < 6; i++) cycle(7, 7);
    chk("locked_after_14", int'(mif.locked), 1);

    // jitter 10/11 within tolerance
    for (int i = 0; i < 5; i++) begin
      cycle(5, 5);
      cycle(5, 6);
    end
    chk("locked_jitter", int'(mif.locked), 1);

    // period equal to the saturation value: rise wins, no timeout
    cycle(10, 53);
    cycle(5, 5);
    chk("no_timeout_at_max", int'(mif.timeout), 0);
    cycle(5, 5);

    // stop toggling -> timeout
    armed = 0;
    repeat (80) @(negedge clk);
    chk("timeout_set", int'(mif.timeout), 1);
    chk("timeout_locked", int'(mif.locked), 0);
    chk("timeout_hold_period", int'(mif.period), last_per);
    chk("timeout_hold_highTime", int'(mif.highTime), last_hi);
    chk("timeout_queue_empty", q.size(), 0);
    have_prev = 0; stable = 0; lk = 0;

    // restart: first rise only arms
    cycle(5, 5);
    chk("timeout_after_restart_rise", int'(mif.timeout), 1);
    cycle(5, 5);
    cycle(5, 5);
    chk("timeout_cleared", int'(mif.timeout), 0);

    // reset mid high phase
    mif.measuredClock = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    mif.measuredClock = 1'b0;
    q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cycle(5, 5);
    chk("no_valid_first_rise_period", int'(mif.period), 0);
    cycle(5, 5);
    cycle(5, 5);

    repeat (10) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
